// File: rtl/fp32_to_fixed.sv
// FP32 to signed fixed-point converter: 4-stage falling-edge pipeline with
// denormalising shift, optional half-away rounding, saturation and status flags.
module fp32_to_fixed #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ROUND = 1
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [31:0]      A,
  output logic             out_valid,
  output logic [WIDTH-1:0] Q,
  output logic             ovf,
  output logic             nan_flag,
  output logic             uf
);
  localparam int MW = WIDTH + 1;
  localparam logic signed [9:0] BIAS_S = 10'sd150;
  localparam logic signed [9:0] FRAC_S = 10'(FRAC);
  localparam logic signed [9:0] SH_MAX = 10'(WIDTH - 23);
  localparam logic [MW-1:0]     POS_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [MW-1:0]     NEG_MAX = {2'b01, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Flow control: an operand is accepted on a falling edge where en=1 and
  // in_valid=1; en=0 freezes every stage and valid bit; there is no backpressure.

  // stage 1: raw fields
  logic        s1_v, s1_s;
  logic [7:0]  s1_e;
  logic [22:0] s1_m;

  // stage 2: classification and shift amount
  logic                s2_v, s2_s, s2_nan, s2_inf, s2_zero, s2_den;
  logic [23:0]         s2_mant;
  logic signed [9:0]   s2_sh;

  // stage 3: magnitude and pre-overflow
  logic          s3_v, s3_s, s3_nan, s3_inf, s3_zero, s3_den, s3_big;
  logic [MW-1:0] s3_mag;

  logic              c2_nan, c2_inf, c2_zero, c2_den;
  logic [23:0]       c2_mant;
  logic signed [9:0] c2_sh;

  always_comb begin
    c2_nan  = (s1_e == 8'hff) && (s1_m != '0);
    c2_inf  = (s1_e == 8'hff) && (s1_m == '0);
    c2_zero = (s1_e == 8'h00);
    c2_den  = (s1_e == 8'h00) && (s1_m != '0);
    c2_mant = {1'b1, s1_m};
    c2_sh   = $signed({2'b00, s1_e}) - BIAS_S + FRAC_S;
  end

  logic signed [9:0] c3_neg;
  logic              c3_rbit;
  logic              c3_big;
  logic [MW-1:0]     c3_mag;

  always_comb begin
    c3_neg  = -s2_sh;
    c3_rbit = 1'b0;
    c3_big  = 1'b0;
    c3_mag  = '0;
    if (!(s2_nan || s2_inf || s2_zero)) begin
      // Exponent too large means the magnitude is at least 2^WIDTH.
      if (s2_sh >= SH_MAX) begin
        c3_big = 1'b1;
      end else if (!s2_sh[9]) begin
        c3_mag = MW'(s2_mant) << s2_sh[5:0];
      end else if (c3_neg < 10'sd25) begin
        c3_mag  = MW'(s2_mant >> c3_neg[4:0]);
        c3_rbit = s2_mant[c3_neg[4:0] - 5'd1];
      end
      if (ROUND == 1) c3_mag = c3_mag + MW'(c3_rbit);
    end
  end

  logic [WIDTH-1:0] c4_q;
  logic             c4_ovf, c4_nan, c4_uf;

  always_comb begin
    c4_q   = '0;
    c4_ovf = 1'b0;
    c4_nan = 1'b0;
    c4_uf  = 1'b0;
    if (s3_nan) begin
      c4_nan = 1'b1;
    end else if (s3_inf || s3_big ||
                 (!s3_s && (s3_mag > POS_MAX)) || (s3_s && (s3_mag > NEG_MAX))) begin
      c4_ovf = 1'b1;
      c4_q   = s3_s ? Q_MIN : Q_MAX;
    end else if (s3_zero) begin
      c4_uf = s3_den;
    end else begin
      c4_q  = s3_s ? ('0 - s3_mag[WIDTH-1:0]) : s3_mag[WIDTH-1:0];
      c4_uf = (s3_mag == '0);
    end
  end

  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s1_s <= 1'b0; s1_e <= '0; s1_m <= '0;
      s2_v <= 1'b0; s2_s <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0;
      s2_zero <= 1'b0; s2_den <= 1'b0; s2_mant <= '0; s2_sh <= '0;
      s3_v <= 1'b0; s3_s <= 1'b0; s3_nan <= 1'b0; s3_inf <= 1'b0;
      s3_zero <= 1'b0; s3_den <= 1'b0; s3_big <= 1'b0; s3_mag <= '0;
      out_valid <= 1'b0; Q <= '0; ovf <= 1'b0; nan_flag <= 1'b0; uf <= 1'b0;
    end else if (en) begin
      s1_v <= in_valid;
      s1_s <= A[31];
      s1_e <= A[30:23];
      s1_m <= A[22:0];

      s2_v    <= s1_v;
      s2_s    <= s1_s;
      s2_nan  <= c2_nan;
      s2_inf  <= c2_inf;
      s2_zero <= c2_zero;
      s2_den  <= c2_den;
      s2_mant <= c2_mant;
      s2_sh   <= c2_sh;

      s3_v    <= s2_v;
      s3_s    <= s2_s;
      s3_nan  <= s2_nan;
      s3_inf  <= s2_inf;
      s3_zero <= s2_zero;
      s3_den  <= s2_den;
      s3_big  <= c3_big;
      s3_mag  <= c3_mag;

      // Outputs only change when a real result arrives; bubbles leave them held.
      out_valid <= s3_v;
      if (s3_v) begin
        Q        <= c4_q;
        ovf      <= c4_ovf;
        nan_flag <= c4_nan;
        uf       <= c4_uf;
      end
    end
  end
endmodule

// File: tb/tb_fp32_to_fixed.sv
// Bench for fp32_to_fixed: real-arithmetic reference model, expected queues,
// one compare process on the rising edge, directed plus random stimulus.
module tb_fp32_to_fixed;
  localparam int W = 32;
  localparam int F = 16;
  localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  logic clk_n = 1'b1;
  logic rst, en, in_valid;
  logic [31:0] A;
  logic ov1, ovf1, nan1, uf1, ov0, ovf0, nan0, uf0;
  logic [W-1:0] q1, q0;

  int checks = 0;
  int errors = 0;
  logic edge_en = 1'b0;
  logic [W+2:0] exp1_q[$];
  logic [W+2:0] exp0_q[$];
  logic [W+2:0] last1 = '0;
  logic [W+2:0] last0 = '0;

  fp32_to_fixed #(.WIDTH(W), .FRAC(F), .ROUND(1)) dut1 (
    .clk_n(clk_n), .rst(rst), .en(en), .in_valid(in_valid), .A(A),
    .out_valid(ov1), .Q(q1), .ovf(ovf1), .nan_flag(nan1), .uf(uf1));

  fp32_to_fixed #(.WIDTH(W), .FRAC(F), .ROUND(0)) dut0 (
    .clk_n(clk_n), .rst(rst), .en(en), .in_valid(in_valid), .A(A),
    .out_valid(ov0), .Q(q0), .ovf(ovf0), .nan_flag(nan0), .uf(uf0));

  always #5 clk_n = ~clk_n;

  // Reference: value * 2^F computed exactly in double, then rounded/clamped.
  function automatic logic [W+2:0] model(input logic [31:0] a, input bit rnd);
    logic s, o, n, u;
    int e, m;
    real v;
    longint mag, lim;
    logic [W-1:0] q;
    s = a[31]; e = int'(a[30:23]); m = int'(a[22:0]);
    q = '0; o = 1'b0; n = 1'b0; u = 1'b0;
    if (e == 255 && m != 0) n = 1'b1;
    else if (e == 255) begin o = 1'b1; q = s ? QMIN : QMAX; end
    else if (e == 0) u = (m != 0);
    else begin
      v = real'(m + 8388608);
      for (int k = 0; k < e - 150 + F; k++) v = v * 2.0;
      for (int k = 0; k < 150 - F - e; k++) v = v / 2.0;
      if (rnd) v = v + 0.5;
      if (v >= 1099511627776.0) mag = 64'sd1 <<< 40;
      else begin
        mag = longint'(v);
        if (real'(mag) > v) mag = mag - 1;
      end
      lim = s ? (64'sd1 <<< (W-1)) : (64'sd1 <<< (W-1)) - 1;
      if (mag > lim) begin o = 1'b1; q = s ? QMIN : QMAX; end
      else begin q = s ? W'(-mag) : W'(mag); u = (mag == 0); end
    end
    return {q, o, n, u};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input bit e);
    @(posedge clk_n); #1;
    en = e; in_valid = v; A = a;
    if (v && e) begin
      exp1_q.push_back(model(a, 1'b1));
      exp0_q.push_back(model(a, 1'b0));
    end
  endtask

  always @(negedge clk_n) edge_en = en && !rst;

  // New results arrive only after an enabled edge; during a stall they must hold.
  always @(posedge clk_n) begin
    if (!rst) begin
      if (ov1) begin
        if (edge_en) begin
          if (exp1_q.size() == 0) chk("unexpected_r1", 64'(ov1), 64'd0);
          else begin
            last1 = exp1_q.pop_front();
            chk("result_r1", 64'({q1, ovf1, nan1, uf1}), 64'(last1));
          end
        end else chk("hold_r1", 64'({q1, ovf1, nan1, uf1}), 64'(last1));
      end
      if (ov0) begin
        if (edge_en) begin
          if (exp0_q.size() == 0) chk("unexpected_r0", 64'(ov0), 64'd0);
          else begin
            last0 = exp0_q.pop_front();
            chk("result_r0", 64'({q0, ovf0, nan0, uf0}), 64'(last0));
          end
        end else chk("hold_r0", 64'({q0, ovf0, nan0, uf0}), 64'(last0));
      end
    end
  end

  initial begin
    logic [31:0] dir_a [12];
    logic [31:0] r;
    int sel;
    dir_a = '{32'h3F800000, 32'hC0200000, 32'h37000000, 32'h00000001,
              32'h80000000, 32'h471C4000, 32'hC7000000, 32'hFF800000,
              32'h7FC00000, 32'h7F800000, 32'hB7000000, 32'h3F7FFFFF};
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; A = '0;

    // Hand-computed pins on the model itself.
    chk("pin_one",    64'(model(32'h3F800000, 1'b1)), 64'({32'h00010000, 3'b000}));
    chk("pin_m2p5",   64'(model(32'hC0200000, 1'b1)), 64'({32'hFFFD8000, 3'b000}));
    chk("pin_tiny_r", 64'(model(32'h37000000, 1'b1)), 64'({32'h00000001, 3'b000}));
    chk("pin_tiny_t", 64'(model(32'h37000000, 1'b0)), 64'({32'h00000000, 3'b001}));
    chk("pin_denorm", 64'(model(32'h00000001, 1'b1)), 64'({32'h00000000, 3'b001}));
    chk("pin_negz",   64'(model(32'h80000000, 1'b1)), 64'({32'h00000000, 3'b000}));
    chk("pin_40000",  64'(model(32'h471C4000, 1'b1)), 64'({32'h7FFFFFFF, 3'b100}));
    chk("pin_m32768", 64'(model(32'hC7000000, 1'b1)), 64'({32'h80000000, 3'b000}));
    chk("pin_ninf",   64'(model(32'hFF800000, 1'b1)), 64'({32'h80000000, 3'b100}));
    chk("pin_nan",    64'(model(32'h7FC00000, 1'b1)), 64'({32'h00000000, 3'b010}));

    repeat (2) @(negedge clk_n);
    #2;
    chk("reset_r1", 64'({ov1, q1, ovf1, nan1, uf1}), 64'd0);
    chk("reset_r0", 64'({ov0, q0, ovf0, nan0, uf0}), 64'd0);
    @(posedge clk_n); #1 rst = 1'b0;

    foreach (dir_a[i]) drive(1'b1, dir_a[i], 1'b1);
    drive(1'b0, '0, 1'b1);

    // Stream 1.0, 2.0, 3.0 with a two-cycle stall in the middle.
    drive(1'b1, 32'h3F800000, 1'b1);
    drive(1'b1, 32'h40000000, 1'b1);
    drive(1'b1, 32'h40400000, 1'b0);
    drive(1'b1, 32'h40400000, 1'b0);
    drive(1'b1, 32'h40400000, 1'b1);
    repeat (8) drive(1'b0, '0, 1'b1);

    // Reset with three operands in flight.
    drive(1'b1, 32'h3F800000, 1'b1);
    drive(1'b1, 32'h40000000, 1'b1);
    drive(1'b1, 32'h40400000, 1'b1);
    drive(1'b0, '0, 1'b1);
    @(posedge clk_n); #2 rst = 1'b1;
    #1;
    chk("midrst_r1", 64'({ov1, q1, ovf1, nan1, uf1}), 64'd0);
    chk("midrst_r0", 64'({ov0, q0, ovf0, nan0, uf0}), 64'd0);
    exp1_q.delete();
    exp0_q.delete();
    @(negedge clk_n);
    @(posedge clk_n); #1 rst = 1'b0;
    repeat (8) drive(1'b0, '0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) r[30:23] = 8'h00;
      else if (sel == 1) r[30:23] = 8'hff;
      else r[30:23] = 8'($urandom_range(95, 165));
      if ($urandom_range(0, 7) == 0) r[22:0] = '0;
      drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 4) != 0);
    end

    repeat (10) drive(1'b0, '0, 1'b1);
    chk("drain_r1", 64'(exp1_q.size()), 64'd0);
    chk("drain_r0", 64'(exp0_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
